// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// the opcode field position, opcode constants, the run-state enumeration
// and a small opcode decode helper.
package fetch_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Opcode field sits in the top six bits of every instruction
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_ADD    = 6'b000000;
  localparam logic [OPC_W-1:0] OP_SHIFTL = 6'b000001;
  localparam logic [OPC_W-1:0] OP_ADDI   = 6'b000010;
  localparam logic [OPC_W-1:0] OP_SUBI   = 6'b000011;
  localparam logic [OPC_W-1:0] OP_BEQ    = 6'b000100;
  localparam logic [OPC_W-1:0] OP_J      = 6'b000110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } run_state_e;

  // True when the opcode field of an instruction encodes an unconditional jump
  function automatic logic is_jump(input logic [OPC_W-1:0] opc);
    return (opc == OP_J);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Run-control state machine for the fetch stage (IDLE / RUN / HALTED).
// Produces the fetch enable (an IF/ID load this cycle) and the valid-clear
// control (drop whatever is in IF/ID). Stall alone produces neither, so
// the IF/ID register simply holds.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic halt_req,
  input  logic stall,
  input  logic redirect_valid,
  output logic fetch_en,
  output logic clear_valid,
  output logic running
);

  run_state_e state_q;
  run_state_e state_d;

  // Run-state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; halt_req beats a simultaneous start while running
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (halt_req) state_d = ST_HALTED;
        else          state_d = ST_RUN;
      end
      ST_HALTED: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_HALTED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch and flush controls; a halt request cancels the fetch of its own cycle
  always_comb begin
    fetch_en    = 1'b0;
    clear_valid = 1'b0;
    if (redirect_valid) begin
      clear_valid = 1'b1;
    end else if (state_q != ST_RUN || halt_req) begin
      clear_valid = 1'b1;
    end else if (!stall) begin
      fetch_en = 1'b1;
    end else begin
      fetch_en    = 1'b0;
      clear_valid = 1'b0;
    end
  end

  assign running = (state_q == ST_RUN);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, addresses the combinational
// instruction memory with it and registers the returned word into the
// IF/ID register. Optional build macro FETCH_EARLY_JUMP_EN resolves
// unconditional jumps in fetch (the jump slot becomes a bubble and the PC
// goes straight to the jump target).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              running
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic              fetch_en;
  logic              clear_valid;
  logic              early_jump;

  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q,    if_pc_d;

  fetch_ctrl u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .fetch_en       (fetch_en),
    .clear_valid    (clear_valid),
    .running        (running)
  );

`ifdef FETCH_EARLY_JUMP_EN
  // A jump fetched on an unstalled, non-redirected cycle is consumed here
  assign early_jump = fetch_en && is_jump(imem_instr[OPC_MSB:OPC_LSB]);
`else
  // Jumps travel down the pipe and come back as a redirect
  assign early_jump = 1'b0;
`endif

  // Next PC: redirect first, then jump target or sequential increment on a fetch
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (early_jump) begin
      pc_d = imem_instr[ADDR_W-1:0];
    end else if (fetch_en) begin
      pc_d = pc_q + PC_ONE;
    end else begin
      pc_d = pc_q;
    end
  end

  // IF/ID next values: load on fetch, clear valid on flush/idle, else hold
  always_comb begin
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if (fetch_en && !early_jump) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_instr;
      if_pc_d    = pc_q;
    end else if (fetch_en || clear_valid) begin
      if_valid_d = 1'b0;
    end else begin
      if_valid_d = if_valid_q;
    end
  end

  // PC and IF/ID pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= ADDR_W'(RESET_PC);
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule
